stepdir_in: RTL
===============

# stepdir_in

Step/dir input decoder: the receiving end of the step/dir interface our `stepdir` generator drives. It synchronises and glitch-filters external STEP and DIR pins (from a handwheel, an external motion controller, or a loop-back from a `stepdir` instance) and accumulates a signed 32-bit position. It optionally measures the step period for velocity readback. It sits beside the other input plugins in `rio`, with its outputs mapped into the FPGA->PC frame.

## Interface

Parameters:
- `FILTER`, default 4: extra clk cycles a synchronised input must stay stable before the filtered level changes. 0 bypasses the filter.
- `DIR_INVERT`, default 0: 1 swaps the count direction.
- `TIMEOUT`, default 2700000: cycles without a step after which `period` reads 0 (stopped).

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: synchronous reset, active low.
- `step`, input, 1: raw STEP pin, asynchronous.
- `dir`, input, 1: raw DIR pin, asynchronous.
- `enable`, input, 1: counting enable. When 0, edges are ignored.
- `clear`, input, 1: synchronous zeroing of `position`.
- `position`, output, 32: signed step count, two's complement.
- `step_pulse`, output, 1: one-cycle strobe per accepted step.
- `period`, output, 32: clk cycles between the last two accepted steps. 0 means stopped or unknown.
- `period_dir`, output, 1: count direction of the last accepted step. 1 means decrementing.

## Operation

- Synchroniser: two flops per input (`s1`, `s2`). Both reset to 0.
- Filter, per input, with a counter of width clog2(FILTER+1):
  - While `s2` equals the filtered level, the counter holds 0.
  - While they differ, the counter increments. When it reaches FILTER, the filtered level takes `s2` and the counter returns to 0.
  - FILTER=0: the filtered level follows `s2` with one register.
  - Filtered levels reset to 0.
- Edge detect: a filtered STEP rising edge (filtered=1, previous=0) is a candidate step.
- Accepted step: a candidate step while `enable`=1.
  - Direction: `dir_f` XOR DIR_INVERT. 0 means +1, 1 means −1.
  - `position` updates modulo 2^32. 0x7FFFFFFF+1 gives 0x80000000; 0x00000000−1 gives 0xFFFFFFFF.
  - `step_pulse`=1 for exactly one cycle.
- `dir_f` is the filtered DIR level in the cycle of the edge.
- A DIR change must precede STEP by at least 1 clk at the filter output, otherwise the old direction is used.
- `clear`=1 forces `position` to 0 and wins over a simultaneous step. `step_pulse` still fires, and `period` logic still runs.
- `enable`=0 suppresses position updates, `step_pulse`, and period updates. The idle counter keeps running.
- Period state machine, states IDLE and RUN:
  - Counter `cnt` saturates at TIMEOUT.
  - IDLE (reset state): an accepted step sets `cnt`=1 and goes to RUN. `period` stays 0.
  - RUN, on an accepted step: `period` <= `cnt`, `cnt` <= 1, `period_dir` updated.
  - RUN, when `cnt` reaches TIMEOUT: `period` <= 0, go to IDLE.
- Reset values: `position`=0, `step_pulse`=0, `period`=0, `period_dir`=0. State is IDLE and all counters are 0.
- Reset mid-operation discards any pending filter count and edge history. No step is generated on release even if `step` is high; the filtered level rises only after the full pipeline delay, and that first rise does count.

## Timing

- Let edge N be the first clk edge that samples the raw `step` high, with `step` held stable.
- Filtered STEP rises at edge N+2+FILTER.
- `position` and `step_pulse` update at edge N+3+FILTER.
- FILTER=0 gives a 3-cycle latency.
- Pulses shorter than FILTER+1 clk at `s2` are rejected, for both high and low glitches.
- Maximum step rate: one accepted step per 2·(FILTER+1) clk.
- `period` and `period_dir` update in the same cycle as `position`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

- Macro `STEPDIR_IN_PERIOD_EN`.
- Defined: period measurement is built as described.
- Undefined: the period logic, `cnt`, and the state machine are removed. `period` is tied to 0 and `period_dir` tracks the direction of the last accepted step with no timeout. Position behaviour is identical.

## Test plan

- Reset release with `step`=1 held, FILTER=4: `position` stays 0 until edge 7 after release, then becomes 1. `step_pulse` is high for one cycle.
- FILTER=4, 3-cycle high glitch on `step`: no `step_pulse` and `position` unchanged. A 5-cycle pulse gives +1 at N+7.
- `dir`=1, 10 steps, then `dir`=0, 4 steps from position 0: `position`=0xFFFFFFFA. With DIR_INVERT=1 the result is 0x00000006.
- Steps every 100 clk, macro defined: `period`=0 after the 1st step, 100 after the 2nd and later steps. No step for TIMEOUT=1000 cycles: `period` returns to 0.
- `clear` asserted in the same cycle as an accepted step at `position`=5: `position`=0, and `step_pulse`=1 that cycle.
- `enable`=0 during 3 steps, then `enable`=1 for 2 steps, starting from 0x7FFFFFFF: `position`=0x80000001 and exactly 2 `step_pulse` strobes.

Source files
------------

// File: rtl/stepdir_in.sv
// stepdir_in -- step/dir input decoder.
//
// Receives STEP/DIR from a handwheel, an external motion controller or a
// loop-back of a stepdir generator. Both pins are synchronised, glitch
// filtered, and each rising edge of the filtered STEP moves a signed 32-bit
// position by one count in the direction given by the filtered DIR.
//
// Optional feature macro: STEPDIR_IN_PERIOD_EN
//   defined   : step period measurement (cnt, IDLE/RUN state machine, timeout)
//   undefined : period is tied to 0, period_dir tracks the last accepted step
//
// Parameters
//   FILTER     : extra clk cycles an input must stay stable before the
//                filtered level follows it (0 = single register, no filter)
//   DIR_INVERT : 1 swaps the count direction
//   TIMEOUT    : cycles without a step after which period reads 0
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous reset, active low
//   step, dir  : raw asynchronous pins
//   enable     : counting enable; edges are ignored while 0
//   clear      : synchronous zeroing of position (wins over a step)
//   position   : signed step count, two's complement
//   step_pulse : one-cycle strobe per accepted step
//   period     : clk cycles between the last two accepted steps, 0 = stopped
//   period_dir : direction of the last accepted step, 1 = decrementing
module stepdir_in #(
  parameter int FILTER     = 4,
  parameter bit DIR_INVERT = 1'b0,
  parameter int TIMEOUT    = 2700000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        dir,
  input  logic        enable,
  input  logic        clear,
  output logic [31:0] position,
  output logic        step_pulse,
  output logic [31:0] period,
  output logic        period_dir
);

  // Index 0 = STEP, index 1 = DIR.
  logic [1:0] raw_in;
  logic [1:0] filt;

  assign raw_in = {dir, step};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_in
      logic s1_reg;
      logic s2_reg;
      logic filt_reg;

      if (FILTER == 0) begin : g_bypass
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            filt_reg <= 1'b0;
          end else begin
            s1_reg   <= raw_in[gi];
            s2_reg   <= s1_reg;
            filt_reg <= s2_reg;
          end
        end
      end else begin : g_filter
        localparam int FW = $clog2(FILTER + 1);
        logic [FW-1:0] cnt_reg;

        // The counter only runs while s2 disagrees with the filtered level;
        // any return to agreement restarts it, so both high and low glitches
        // shorter than FILTER+1 cycles are dropped.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            filt_reg <= 1'b0;
            cnt_reg  <= '0;
          end else begin
            s1_reg <= raw_in[gi];
            s2_reg <= s1_reg;
            if (s2_reg == filt_reg) begin
              cnt_reg <= '0;
            end else if (cnt_reg == FW'(FILTER)) begin
              filt_reg <= s2_reg;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic step_prev_reg;
  logic accept;
  logic cnt_dir;

  // Edge history is cleared by reset, so a STEP held high through reset
  // produces exactly one step once it has crossed the pipeline.
  assign accept  = filt[0] & ~step_prev_reg & enable;
  assign cnt_dir = filt[1] ^ DIR_INVERT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_prev_reg <= 1'b0;
      step_pulse    <= 1'b0;
      position      <= '0;
    end else begin
      step_prev_reg <= filt[0];
      step_pulse    <= accept;
      if (clear) begin
        position <= '0;
      end else if (accept) begin
        position <= cnt_dir ? position - 32'd1 : position + 32'd1;
      end
    end
  end

`ifdef STEPDIR_IN_PERIOD_EN
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

  state_t      state_reg;
  logic [31:0] cnt_reg;

  // cnt holds the number of cycles since the last accepted step; it never
  // exceeds TIMEOUT because reaching it drops back to IDLE. A step arriving
  // exactly at TIMEOUT is still measured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      period     <= '0;
      period_dir <= 1'b0;
    end else begin
      if (accept) begin
        period_dir <= cnt_dir;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg   <= 32'd1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            period  <= cnt_reg;
            cnt_reg <= 32'd1;
          end else if (cnt_reg >= TIMEOUT_C) begin
            period    <= '0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end
`else
  assign period = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_dir <= 1'b0;
    end else if (accept) begin
      period_dir <= cnt_dir;
    end
  end
`endif

endmodule
